// File: rtl/multdiv_unit.sv
// Iterative 32-bit signed multiply/divide engine: radix-4 Booth multiplier
// (17-cycle latency) and non-restoring magnitude divider (34-cycle latency).
module multdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic        is_mul_reg;
  logic [33:0] acc_reg;
  logic [31:0] mq_reg;
  logic        prev_reg;
  logic [31:0] mcand_reg;
  logic [32:0] rem_reg;
  logic [31:0] quot_reg;
  logic [31:0] dvs_reg;
  logic        neg_reg;
  logic        dvz_reg;
  logic        ovf_reg;

  logic        start;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [33:0] mcand_ext;
  logic [33:0] booth_addend;
  logic [33:0] acc_sum;
  logic [33:0] acc_next;
  logic [31:0] mq_next;
  logic [32:0] rem_shift;
  logic [32:0] rem_next;
  logic [31:0] quot_next;
  logic        mul_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign a_abs     = data_operandA[31] ? -data_operandA : data_operandA;
  assign b_abs     = data_operandB[31] ? -data_operandB : data_operandB;
  assign mcand_ext = {{2{mcand_reg[31]}}, mcand_reg};

  // Booth digit from {b(i+1), b(i), b(i-1)}
  always_comb begin
    booth_addend = '0;
    case ({mq_reg[1:0], prev_reg})
      3'b001, 3'b010: booth_addend = mcand_ext;
      3'b011:         booth_addend = {mcand_ext[32:0], 1'b0};
      3'b100:         booth_addend = -{mcand_ext[32:0], 1'b0};
      3'b101, 3'b110: booth_addend = -mcand_ext;
      default:        booth_addend = '0;
    endcase
  end

  assign acc_sum  = acc_reg + booth_addend;
  assign acc_next = {{2{acc_sum[33]}}, acc_sum[33:2]};
  assign mq_next  = {acc_sum[1:0], mq_reg[31:2]};

  // Product high word sits in acc_reg[31:0], low word in mq_reg
  assign mul_exc  = acc_reg[31:0] != {32{mq_reg[31]}};

  assign rem_shift = {rem_reg[31:0], quot_reg[31]};
  assign rem_next  = rem_reg[32] ? rem_shift + {1'b0, dvs_reg}
                                 : rem_shift - {1'b0, dvs_reg};
  assign quot_next = {quot_reg[30:0], ~rem_next[32]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      is_mul_reg     <= 1'b0;
      acc_reg        <= '0;
      mq_reg         <= '0;
      prev_reg       <= 1'b0;
      mcand_reg      <= '0;
      rem_reg        <= '0;
      quot_reg       <= '0;
      dvs_reg        <= '0;
      neg_reg        <= 1'b0;
      dvz_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_reg)
        MUL: begin
          acc_reg  <= acc_next;
          mq_reg   <= mq_next;
          prev_reg <= mq_reg[1];
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd15) state_reg <= DONE;
        end
        DIV: begin
          rem_reg  <= rem_next;
          quot_reg <= quot_next;
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) state_reg <= FIX;
        end
        FIX: begin
          if (dvz_reg)      quot_reg <= '0;
          else if (neg_reg) quot_reg <= -quot_reg;
          state_reg <= DONE;
        end
        DONE: begin
          data_result    <= is_mul_reg ? mq_reg : quot_reg;
          data_exception <= is_mul_reg ? mul_exc : (dvz_reg | ovf_reg);
          data_resultRDY <= 1'b1;
          state_reg      <= IDLE;
        end
        default: ;
      endcase
      // A start overrides any step in progress; a publish in DONE still happens
      if (start) begin
        is_mul_reg <= ctrl_MULT;
        state_reg  <= ctrl_MULT ? MUL : DIV;
        cnt_reg    <= '0;
        acc_reg    <= '0;
        mq_reg     <= data_operandB;
        prev_reg   <= 1'b0;
        mcand_reg  <= data_operandA;
        rem_reg    <= '0;
        quot_reg   <= a_abs;
        dvs_reg    <= b_abs;
        neg_reg    <= data_operandA[31] ^ data_operandB[31];
        dvz_reg    <= (data_operandB == 32'd0);
        ovf_reg    <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit with a queue scoreboard of
// expected {exception, result} pairs pushed at start and popped at each ready pulse.
module tb_multdiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  logic [32:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  multdiv_unit dut (
    .clk            (clk),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return {(p[63:32] != {32{p[31]}}), p[31:0]};
  endfunction

  function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
    int x;
    int y;
    int q;
    x = signed'(a);
    y = signed'(b);
    if (y == 0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && y == -1) return {1'b1, 32'h8000_0000};
    q = x / y;
    return {1'b0, q};
  endfunction

  // Leaves the bench 1 time unit after E0
  task automatic start_pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_result(input string tag, input int lat, input int window);
    int first = -1;
    int pulses = 0;
    logic [32:0] exp;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({tag, "_result"}, 64'(data_result), 64'(exp[31:0]));
            check({tag, "_exc"}, 64'(data_exception), 64'(exp[32]));
          end
        end
      end
    end
    check({tag, "_latency"}, 64'(first), 64'(lat));
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    if (first < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
    $display("%s done: result=%08h exc=%0b ready_after=%0d", tag, data_result, data_exception, first);
  endtask

  task automatic do_op(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = m ? 17 : 34;
    sb_q.push_back(m ? mul_model(a, b) : div_model(a, b));
    start_pulse(m, d, a, b);
    wait_result(tag, lat, lat + 3);
  endtask

  initial begin
    int pulses;
    logic [32:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    do_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    do_op("mul_min_fit", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000);
    do_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    do_op("mul_both_ctrl", 1'b1, 1'b1, 32'd6, 32'd3);
    do_op("div_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    do_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    do_op("div_6_7", 1'b0, 1'b1, 32'd6, 32'd7);
    do_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op("div_by_zero", 1'b0, 1'b1, 32'd5, 32'd0);
    do_op("div_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op("mul_rand", 1'b1, 1'b0, ra, rb);
      ra = $urandom;
      rb = $urandom_range(1, 65535);
      do_op("div_rand", 1'b0, 1'b1, ra, rb);
    end

    // Restart: divide at E0, multiply at E10, single publish at E27
    start_pulse(1'b0, 1'b1, 32'd9, 32'd3);
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) pulses++;
    end
    check("restart_early_rdy", 64'(pulses), 64'd0);
    sb_q.push_back(mul_model(32'd6, 32'd7));
    start_pulse(1'b1, 1'b0, 32'd6, 32'd7);
    wait_result("restart", 17, 26);

    // Asynchronous reset between E8 and E9 of a multiply
    start_pulse(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_result", 64'(data_result), 64'd0);
    check("async_rst_exc", 64'(data_exception), 64'd0);
    check("async_rst_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY === 1'b1) pulses++;
    end
    check("async_rst_no_rdy", 64'(pulses), 64'd0);
    do_op("post_reset", 1'b1, 1'b0, 32'd11, 32'hFFFF_FFF3);

    // Back-to-back: second start lands on the first publish edge
    sb_q.push_back(mul_model(32'd1234, 32'd5678));
    start_pulse(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (16) @(posedge clk);
    sb_q.push_back(mul_model(32'hFFFF_FFF0, 32'd9));
    start_pulse(1'b1, 1'b0, 32'hFFFF_FFF0, 32'd9);
    check("b2b_first_rdy", 64'(data_resultRDY), 64'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check("b2b_first_result", 64'(data_result), 64'(exp[31:0]));
      check("b2b_first_exc", 64'(data_exception), 64'(exp[32]));
    end
    $display("b2b_first done: result=%08h exc=%0b", data_result, data_exception);
    wait_result("b2b_second", 17, 19);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
